// File: rtl/uart_echo.sv
// UART loopback: 8N1 receiver timed by an oversampling counter, one-byte holding register,
// and a transmitter paced by the external clk_en baud tick.
module uart_echo #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clk_en,
    input  logic rx,
    output logic tx
);
    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] FullLast = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

    logic            rx_meta_q, rx_s_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic            rx_done;

    logic [7:0]      hold_q, hold_d;
    logic            full_q, full_d;

    tx_state_e       tx_state_q, tx_state_d;
    logic [7:0]      tx_shift_q, tx_shift_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic            tx_q, tx_d;
    logic            tx_take;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (!rx_s_q) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                end
            end
            RxStart: begin
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_s_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxData: begin
                if (rx_cnt_q == FullLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RxStop;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == FullLast) begin
                    rx_cnt_d   = '0;
                    rx_done    = rx_s_q;  // stop bit low is a framing error: byte discarded
                    rx_state_d = RxIdle;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_d       = tx_q;
        tx_take    = 1'b0;
        if (clk_en) begin
            unique case (tx_state_q)
                TxIdle: begin
                    tx_d = 1'b1;
                    if (full_q) begin
                        tx_take    = 1'b1;
                        tx_shift_d = hold_q;
                        tx_d       = 1'b0;
                        tx_state_d = TxStart;
                    end
                end
                TxStart: begin
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = '0;
                    tx_state_d = TxData;
                end
                TxData: begin
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = TxStop;
                    end else begin
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end
                TxStop: begin
                    tx_d       = 1'b1;
                    tx_state_d = TxIdle;
                end
                default: tx_state_d = TxIdle;
            endcase
        end
    end

    // A take and a new byte on the same clock: the take empties the slot, so the byte loads.
    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        if (tx_take) begin
            full_d = 1'b0;
        end
        if (rx_done && (!full_q || tx_take)) begin
            hold_d = rx_shift_q;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            hold_q     <= '0;
            full_q     <= 1'b0;
            tx_state_q <= TxIdle;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            hold_q     <= hold_d;
            full_q     <= full_d;
            tx_state_q <= tx_state_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
        end
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_uart_echo.sv
// Bench for uart_echo: byte-level model of the holding slot and transmitter occupancy,
// plus a line monitor that decodes tx on every baud tick.
module tb_uart_echo;
    localparam int unsigned CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_en = 1'b0;
    logic rx = 1'b1;
    logic tx;

    uart_echo #(.CLKS_PER_BIT(CPB)) dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .rx     (rx),
        .tx     (tx)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned en_period = 16;
    int unsigned en_cnt = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            en_cnt++;
            clk_en = ((en_cnt % en_period) == 0);
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int unsigned comp_cyc[$];
    logic [7:0]  comp_byte[$];
    bit          m_full = 1'b0;
    logic [7:0]  m_hold = 8'h00;
    int          m_busy = 0;
    int          m_done_cnt = 0;
    int          dut_done_cnt = 0;
    int          m_base = 0;
    int          dut_base = 0;
    int unsigned last_c0 = 0;
    int unsigned last_done_cyc = 0;
    bit          rst_seen = 1'b1;
    bit          en_seen = 1'b0;
    logic        tx_prev = 1'b1;
    int          mon_cnt = -1;
    logic [7:0]  mon_byte = 8'h00;

    task automatic check(input bit ok, input string name, input longint act, input longint expv);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Model step per clock edge: take on a tick when the line is free, then accept completions.
    always @(negedge clk) begin
        logic [7:0] e;
        logic [7:0] b;
        if (dut.rx_done === 1'b1) begin
            dut_done_cnt++;
            last_done_cyc = cyc;
        end
        if (rst_seen) begin
            check(tx === 1'b1, "rst_tx", tx, 1);
            check(dut.full_q === 1'b0, "rst_full", dut.full_q, 0);
            m_full = 1'b0;
            m_busy = 0;
            exp_q.delete();
            mon_cnt = -1;
        end else begin
            check((tx === tx_prev) || en_seen, "tx_glitch", tx, tx_prev);
            if (en_seen) begin
                if (mon_cnt < 0) begin
                    if (tx === 1'b0) mon_cnt = 0;
                end else if (mon_cnt < 8) begin
                    mon_byte = {tx, mon_byte[7:1]};
                    mon_cnt++;
                end else begin
                    check(tx === 1'b1, "stop_bit", tx, 1);
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_frame", mon_byte, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check(mon_byte === e, "echo_byte", mon_byte, e);
                    end
                    got_q.push_back(mon_byte);
                    mon_cnt = -1;
                end
                if (m_busy > 0) begin
                    m_busy--;
                end else if (m_full) begin
                    exp_q.push_back(m_hold);
                    m_full = 1'b0;
                    m_busy = 10;
                end
            end
        end
        while (comp_cyc.size() > 0 && comp_cyc[0] <= cyc) begin
            void'(comp_cyc.pop_front());
            b = comp_byte.pop_front();
            m_done_cnt++;
            if (!m_full) begin
                m_hold = b;
                m_full = 1'b1;
            end
        end
        tx_prev  = tx;
        en_seen  = clk_en;
        rst_seen = rst;
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Caller is aligned just after a rising edge; the byte completes 155 edges after the start edge.
    task automatic send(input logic [7:0] b, input bit stop_ok);
        last_c0 = cyc;
        if (stop_ok) begin
            comp_cyc.push_back(cyc + 155);
            comp_byte.push_back(b);
        end
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx = stop_ok;
        repeat (CPB) @(posedge clk);
        #1;
        rx = 1'b1;
    endtask

    task automatic drain(input int bound, input string name);
        int i;
        for (i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !m_full && m_busy == 0 && mon_cnt < 0 &&
                comp_cyc.size() == 0) break;
        end
        check(i < bound, name, i, bound);
        align();
    endtask

    task automatic check_got(input string name, input int n, input logic [7:0] b0,
                             input logic [7:0] b1, input int n_done);
        check(got_q.size() == n, {name, "_count"}, got_q.size(), n);
        if (n > 0 && got_q.size() > 0) check(got_q[0] === b0, {name, "_byte0"}, got_q[0], b0);
        if (n > 1 && got_q.size() > 1) check(got_q[1] === b1, {name, "_byte1"}, got_q[1], b1);
        check(m_done_cnt - m_base == n_done, {name, "_model_done"}, m_done_cnt - m_base, n_done);
        check(dut_done_cnt - dut_base == n_done, {name, "_rx_done"}, dut_done_cnt - dut_base,
              n_done);
        got_q.delete();
        m_base   = m_done_cnt;
        dut_base = dut_done_cnt;
    endtask

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected fewer", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;
        int i;
        logic [7:0] b;
        bit ok;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        align();

        // Basic echo, with exact receive latency on the first frame
        send(8'h3C, 1'b1);
        c0 = last_c0;
        check(last_done_cyc - c0 == 154, "rx_done_latency", last_done_cyc - c0, 154);
        repeat (200) @(posedge clk);
        #1;
        send(8'hA5, 1'b1);
        drain(3000, "drain_basic");
        check_got("basic", 2, 8'h3C, 8'hA5, 2);

        // Back-to-back frames, no idle gap
        send(8'h55, 1'b1);
        send(8'hAA, 1'b1);
        drain(3000, "drain_b2b");
        check_got("b2b", 2, 8'h55, 8'hAA, 2);

        // False start
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        check_got("false_start", 0, 8'h00, 8'h00, 0);

        // Framing error then a good byte
        send(8'h81, 1'b0);
        repeat (48) @(posedge clk);
        #1;
        send(8'h12, 1'b1);
        drain(3000, "drain_framing");
        check_got("framing", 1, 8'h12, 8'h00, 1);

        // Reset during TX data bit 3
        send(8'hF0, 1'b1);
        for (i = 0; i < 1000; i++) begin
            @(negedge clk);
            #1;
            if (mon_cnt == 4) break;
        end
        check(i < 1000, "wait_bit3", i, 1000);
        align();
        rst = 1'b1;
        align();
        rst = 1'b0;
        repeat (4) align();
        send(8'h0F, 1'b1);
        drain(3000, "drain_reset");
        check_got("reset", 1, 8'h0F, 8'h00, 2);

        // Overflow with slow transmit
        en_period = 64;
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        send(8'h03, 1'b1);
        drain(6000, "drain_overflow");
        check_got("overflow", 2, 8'h01, 8'h02, 3);
        en_period = 16;
        repeat (20) align();

        // Random traffic, occasional framing errors
        for (int k = 0; k < 12; k++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            send(b, ok);
            repeat ($urandom_range(32, 80)) @(posedge clk);
            #1;
        end
        drain(4000, "drain_random");
        check(dut_done_cnt - dut_base == m_done_cnt - m_base, "random_rx_done",
              dut_done_cnt - dut_base, m_done_cnt - m_base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
